tri_st_popcnt_seq: RTL and testbench



---
 rtl/tri_st_popcnt_pkg.sv | 31 +++
 rtl/tri_st_popcnt_seq_word.sv | 22 ++
 rtl/tri_st_popcnt_seq.sv | 110 +++++++++++
 tb/tb_tri_st_popcnt_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tri_st_popcnt_pkg.sv
// rtl/tri_st_popcnt_pkg.sv - shared encodings, result field positions and byte popcount helper
package tri_st_popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    W0   = 2'b01,
    W1   = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic POPCNTW = 1'b0;
  localparam logic POPCNTD = 1'b1;

  // Result fields in big-endian bit numbering (bit 0 = MSB)
  localparam int W_HI_MSB = 26;
  localparam int W_HI_LSB = 31;
  localparam int W_LO_MSB = 58;
  localparam int W_LO_LSB = 63;
  localparam int D_MSB    = 57;
  localparam int D_LSB    = 63;

  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/tri_st_popcnt_seq_word.sv
// rtl/tri_st_popcnt_seq_word.sv - combinational 32-bit word population counter
module tri_st_popcnt_word
  import tri_st_popcnt_pkg::*;
(
  inout  wire         vdd,
  inout  wire         gnd,
  input  logic [0:31] a_i,
  output logic [5:0]  y_o
);

  logic unused_pwr;
  assign unused_pwr = vdd & ~gnd;

  // Four byte counts b0..b3 summed into a 6-bit total (max 32)
  always_comb begin
    y_o = '0;
    for (int i = 0; i < 4; i++) begin
      y_o = y_o + {2'b00, popcnt8(a_i[8*i +: 8])};
    end
  end

endmodule

// File: rtl/tri_st_popcnt_seq.sv
// rtl/tri_st_popcnt_seq.sv - two-cycle 64-bit popcount sequencer over one shared word counter
module tri_st_popcnt_seq
  import tri_st_popcnt_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  inout  wire                        vdd,
  inout  wire                        gnd,
  input  logic                       ex_valid,
  output logic                       ex_ready,
  input  logic                       ex_mode,
  input  logic [$clog2(THREADS)-1:0] ex_tid,
  input  logic [0:63]                ex_op,
  input  logic [0:THREADS-1]         flush,
  output logic                       rslt_valid,
  input  logic                       rslt_ready,
  output logic [$clog2(THREADS)-1:0] rslt_tid,
  output logic [0:63]                rslt
);

  localparam int TW = $clog2(THREADS);

  state_e          state_q, state_d;
  logic [0:63]     op_q, op_d;
  logic            mode_q, mode_d;
  logic [TW-1:0]   tid_q, tid_d;
  logic [5:0]      cnt0_q, cnt0_d;
  logic [5:0]      cnt1_q, cnt1_d;
  logic [0:31]     word_in;
  logic [5:0]      word_cnt;
  logic            accept;
  logic [6:0]      dsum;

  assign word_in = (state_q == W1) ? op_q[32:63] : op_q[0:31];

  tri_st_popcnt_word u_word (
    .vdd (vdd),
    .gnd (gnd),
    .a_i (word_in),
    .y_o (word_cnt)
  );

  assign ex_ready   = (state_q == IDLE) | ((state_q == DONE) & rslt_ready);
  assign accept     = ex_valid & ex_ready & ~flush[ex_tid];
  assign rslt_valid = (state_q == DONE);
  assign rslt_tid   = tid_q;
  assign dsum       = {1'b0, cnt0_q} + {1'b0, cnt1_q};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    mode_d  = mode_q;
    tid_d   = tid_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (accept) begin
      op_d   = ex_op;
      mode_d = ex_mode;
      tid_d  = ex_tid;
    end
    case (state_q)
      IDLE: if (accept) state_d = W0;
      W0: begin
        cnt0_d  = word_cnt;
        state_d = flush[tid_q] ? IDLE : W1;
      end
      W1: begin
        cnt1_d  = word_cnt;
        state_d = flush[tid_q] ? IDLE : DONE;
      end
      DONE: begin
        // A completing handshake wins over a flush of the result's thread
        if (rslt_ready)        state_d = accept ? W0 : IDLE;
        else if (flush[tid_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rslt = '0;
    if (mode_q == POPCNTD) begin
      rslt[D_MSB:D_LSB] = dsum;
    end else begin
      rslt[W_HI_MSB:W_HI_LSB] = cnt0_q;
      rslt[W_LO_MSB:W_LO_LSB] = cnt1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      mode_q  <= POPCNTW;
      tid_q   <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      mode_q  <= mode_d;
      tid_q   <= tid_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

endmodule

// File: tb/tb_tri_st_popcnt_seq.sv
// tb/tb_tri_st_popcnt_seq.sv - randomized self-checking bench for tri_st_popcnt_seq
module tb_tri_st_popcnt_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  wire         vdd = 1'b1;
  wire         gnd = 1'b0;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_mode;
  logic [1:0]  ex_tid;
  logic [63:0] ex_op;
  logic [0:3]  flush;
  logic        rslt_valid;
  logic        rslt_ready;
  logic [1:0]  rslt_tid;
  logic [63:0] rslt;

  int n_checks = 0;
  int n_errors = 0;

  tri_st_popcnt_seq #(.THREADS(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vdd        (vdd),
    .gnd        (gnd),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_mode    (ex_mode),
    .ex_tid     (ex_tid),
    .ex_op      (ex_op),
    .flush      (flush),
    .rslt_valid (rslt_valid),
    .rslt_ready (rslt_ready),
    .rslt_tid   (rslt_tid),
    .rslt       (rslt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // popcntw: high word count lands at bit 32 upward, low word count at bit 0
  function automatic logic [63:0] ref_pop(input logic m, input logic [63:0] v);
    if (m) return 64'($countones(v));
    return {32'($countones(v[63:32])), 32'($countones(v[31:0]))};
  endfunction

  task automatic run_op(input logic m, input logic [1:0] t, input logic [63:0] v,
                        input int stall, input logic [0:3] fl_other);
    logic [63:0] exp;
    logic [0:3]  f;
    exp = ref_pop(m, v);
    f = fl_other;
    f[t] = 1'b0;
    flush = f;
    ex_valid = 1'b1; ex_mode = m; ex_tid = t; ex_op = v;
    #1;
    check("ex_ready_idle", ex_ready, 1);
    cyc();
    ex_valid = 1'b0; ex_op = {$urandom, $urandom}; ex_mode = ~m; ex_tid = ~t;
    check("lat_n1", rslt_valid, 0);
    cyc();
    check("lat_n2", rslt_valid, 0);
    cyc();
    check("lat_n3", rslt_valid, 1);
    check("rslt", rslt, exp);
    check("rslt_tid", rslt_tid, t);
    for (int i = 0; i < stall; i++) begin
      check("ex_ready_stall", ex_ready, 0);
      cyc();
      check("stall_valid", rslt_valid, 1);
      check("stall_rslt", rslt, exp);
      check("stall_tid", rslt_tid, t);
    end
    rslt_ready = 1'b1;
    #1;
    check("ex_ready_done", ex_ready, 1);
    cyc();
    rslt_ready = 1'b0;
    flush = '0;
    check("consumed", rslt_valid, 0);
  endtask

  initial begin
    logic [63:0] e1, e2;
    rst_n = 1'b0; ex_valid = 1'b0; ex_mode = 1'b0; ex_tid = 2'd0; ex_op = '0;
    flush = '0; rslt_ready = 1'b0;
    cyc(); cyc();
    check("rst_valid", rslt_valid, 0);
    check("rst_ready", ex_ready, 1);
    check("rst_rslt", rslt, 0);
    check("rst_tid", rslt_tid, 0);
    rst_n = 1'b1;
    cyc();

    run_op(1'b1, 2'd0, 64'hFFFF_FFFF_0000_0001, 0, 4'b0000);
    check("dir_popcntd", ref_pop(1'b1, 64'hFFFF_FFFF_0000_0001), 64'h21);
    run_op(1'b0, 2'd1, 64'hFFFF_FFFF_0000_0001, 0, 4'b0000);
    run_op(1'b1, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b0000);
    run_op(1'b1, 2'd2, 64'h0, 0, 4'b0000);
    run_op(1'b0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'b0000);

    // Stall 5 cycles, then back-to-back accept
    e1 = ref_pop(1'b0, 64'h8000_0001_F0F0_0F0F);
    e2 = ref_pop(1'b1, 64'h0123_4567_89AB_CDEF);
    ex_valid = 1'b1; ex_mode = 1'b0; ex_tid = 2'd1; ex_op = 64'h8000_0001_F0F0_0F0F;
    cyc();
    ex_valid = 1'b0;
    cyc(); cyc();
    check("b2b_valid1", rslt_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("b2b_hold_ready", ex_ready, 0);
      check("b2b_hold_rslt", rslt, e1);
      check("b2b_hold_tid", rslt_tid, 1);
      cyc();
    end
    rslt_ready = 1'b1;
    ex_valid = 1'b1; ex_mode = 1'b1; ex_tid = 2'd3; ex_op = 64'h0123_4567_89AB_CDEF;
    #1;
    check("b2b_ready", ex_ready, 1);
    cyc();
    rslt_ready = 1'b0; ex_valid = 1'b0;
    check("b2b_w0", rslt_valid, 0);
    cyc();
    check("b2b_w1", rslt_valid, 0);
    cyc();
    check("b2b_valid2", rslt_valid, 1);
    check("b2b_rslt2", rslt, e2);
    check("b2b_tid2", rslt_tid, 3);
    rslt_ready = 1'b1;
    cyc();
    rslt_ready = 1'b0;

    // Own-thread flush in W1 kills the op
    ex_valid = 1'b1; ex_mode = 1'b1; ex_tid = 2'd2; ex_op = 64'hFFFF;
    cyc();
    ex_valid = 1'b0;
    cyc();
    flush = 4'b0010;
    cyc();
    flush = '0;
    check("flush_w1_idle", rslt_valid, 0);
    check("flush_w1_ready", ex_ready, 1);
    cyc();
    check("flush_w1_nores", rslt_valid, 0);
    cyc();
    check("flush_w1_nores2", rslt_valid, 0);

    // Other-thread flush has no effect
    run_op(1'b1, 2'd2, 64'hAAAA_5555_0000_FFFF, 1, 4'b0100);

    // Flush in the request cycle drops the request
    ex_valid = 1'b1; ex_mode = 1'b0; ex_tid = 2'd1; ex_op = 64'h1234; flush = 4'b0100;
    cyc();
    ex_valid = 1'b0; flush = '0;
    for (int i = 0; i < 4; i++) begin
      check("drop_nores", rslt_valid, 0);
      check("drop_ready", ex_ready, 1);
      cyc();
    end

    // Reset in W0
    ex_valid = 1'b1; ex_mode = 1'b1; ex_tid = 2'd3; ex_op = 64'hFFFF_0000_FFFF_0000;
    cyc();
    ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rstw0_valid", rslt_valid, 0);
    check("rstw0_ready", ex_ready, 1);
    check("rstw0_rslt", rslt, 0);
    check("rstw0_tid", rslt_tid, 0);
    cyc(); cyc(); cyc();
    check("rstw0_hold", rslt_valid, 0);
    rst_n = 1'b1;
    cyc();
    run_op(1'b0, 2'd1, 64'hFFFF_0000_FFFF_0000, 0, 4'b0000);

    for (int k = 0; k < 40; k++) begin
      logic [63:0] v;
      case ($urandom_range(0, 5))
        0: v = '0;
        1: v = '1;
        default: v = {$urandom, $urandom};
      endcase
      run_op(1'($urandom), 2'($urandom), v, int'($urandom_range(0, 3)), 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
